// File: rtl/gps_pkg.sv
// Shared definitions for the GPS L1 C/A code generator.
//   state_t    : controller states
//   CA_LEN     : chips per C/A code period
//   G1_TAPS    : G1 feedback taps as a mask over stage indices 10..1
//   G2_TAPS    : G2 feedback taps as a mask over stage indices 10..1
//   prn_taps() : PRN -> {t1, t2} G2 phase-selector taps, 0 for unknown PRN
package gps_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SLEW = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam int unsigned CA_LEN  = 1023;
   localparam int unsigned PRN_MAX = 32;

   // Bit i of the mask selects stage i (vector indexed [10:1])
   localparam logic [10:1] G1_TAPS = 10'b10_0000_0100;   // stages 3, 10
   localparam logic [10:1] G2_TAPS = 10'b11_1010_0110;   // stages 2,3,6,8,9,10

   // G2 phase-selector tap pair for each satellite PRN
   function automatic logic [7:0] prn_taps(input logic [5:0] prn);
      logic [7:0] t;
      case (prn)
         6'd1:    t = {4'd2, 4'd6};
         6'd2:    t = {4'd3, 4'd7};
         6'd3:    t = {4'd4, 4'd8};
         6'd4:    t = {4'd5, 4'd9};
         6'd5:    t = {4'd1, 4'd9};
         6'd6:    t = {4'd2, 4'd10};
         6'd7:    t = {4'd1, 4'd8};
         6'd8:    t = {4'd2, 4'd9};
         6'd9:    t = {4'd3, 4'd10};
         6'd10:   t = {4'd2, 4'd3};
         6'd11:   t = {4'd3, 4'd4};
         6'd12:   t = {4'd5, 4'd6};
         6'd13:   t = {4'd6, 4'd7};
         6'd14:   t = {4'd7, 4'd8};
         6'd15:   t = {4'd8, 4'd9};
         6'd16:   t = {4'd9, 4'd10};
         6'd17:   t = {4'd1, 4'd4};
         6'd18:   t = {4'd2, 4'd5};
         6'd19:   t = {4'd3, 4'd6};
         6'd20:   t = {4'd4, 4'd7};
         6'd21:   t = {4'd5, 4'd8};
         6'd22:   t = {4'd6, 4'd9};
         6'd23:   t = {4'd1, 4'd3};
         6'd24:   t = {4'd4, 4'd6};
         6'd25:   t = {4'd5, 4'd7};
         6'd26:   t = {4'd6, 4'd8};
         6'd27:   t = {4'd7, 4'd9};
         6'd28:   t = {4'd8, 4'd10};
         6'd29:   t = {4'd1, 4'd6};
         6'd30:   t = {4'd2, 4'd7};
         6'd31:   t = {4'd3, 4'd8};
         6'd32:   t = {4'd4, 4'd9};
         default: t = 8'h00;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/gps_ca_lfsr.sv
// G1/G2 shift registers and chip output for one PRN.
//   clk, rst     : clock, synchronous active-high reset
//   load         : set both registers to all-ones and latch tap1/tap2
//   reseed       : set both registers to all-ones, keep latched taps
//   adv          : advance both registers by one chip
//   en           : chip output enable (chip forced to 0 when low)
//   tap1, tap2   : G2 phase-selector taps, sampled on load
//   chip         : G1[10] ^ G2[t1] ^ G2[t2], from registered state only
module gps_ca_lfsr
   import gps_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       reseed,
   input  logic       adv,
   input  logic       en,
   input  logic [3:0] tap1,
   input  logic [3:0] tap2,
   output logic       chip
);

   logic [10:1] g1;
   logic [10:1] g2;
   logic [3:0]  t1_q;
   logic [3:0]  t2_q;
   logic [15:0] g2_ext;

   // Registers shift toward stage 10; feedback enters stage 1
   always_ff @(posedge clk) begin
      if (rst) begin
         g1   <= '1;
         g2   <= '1;
         t1_q <= 4'd0;
         t2_q <= 4'd0;
      end else if (load) begin
         g1   <= '1;
         g2   <= '1;
         t1_q <= tap1;
         t2_q <= tap2;
      end else if (reseed) begin
         g1 <= '1;
         g2 <= '1;
      end else if (adv) begin
         g1 <= {g1[9:1], ^(g1 & G1_TAPS)};
         g2 <= {g2[9:1], ^(g2 & G2_TAPS)};
      end
   end

   // Zero-padded so any 4-bit tap value indexes in range (tap 0 reads 0)
   always_comb begin
      g2_ext = {5'b0, g2, 1'b0};
      chip   = en & (g1[10] ^ g2_ext[t1_q] ^ g2_ext[t2_q]);
   end

endmodule

// File: rtl/gps_ca_code_gen.sv
// GPS L1 C/A code replica generator driven by a code-rate NCO.
//   clk, rst    : clock, synchronous active-high reset
//   start       : load prn/init_phase/code_freq and (re)start
//   stop        : return to IDLE (wins over start)
//   prn         : satellite PRN 1..32
//   init_phase  : initial chip delay 0..CA_LEN-1, reached by fast slewing
//   code_freq   : NCO increment per sample_en (2^NCO_BITS = 1 chip/sample)
//   sample_en   : one-cycle ADC sample strobe
//   chip        : current C/A chip, 0 when idle
//   chip_idx    : index of current chip
//   chip_adv    : pulse when chip/chip_idx advanced in RUN
//   epoch       : pulse when chip_idx wrapped to 0 in RUN
//   busy        : high in SLEW or RUN
//   err         : pulse when a start carried invalid arguments
module gps_ca_code_gen
   import gps_pkg::*;
#(
   parameter int unsigned NCO_BITS = 32,
   parameter int unsigned CA_LEN   = 1023
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic [5:0]          prn,
   input  logic [9:0]          init_phase,
   input  logic [NCO_BITS-1:0] code_freq,
   input  logic                sample_en,
   output logic                chip,
   output logic [9:0]          chip_idx,
   output logic                chip_adv,
   output logic                epoch,
   output logic                busy,
   output logic                err
);

   state_t              state;
   logic [NCO_BITS-1:0] nco;
   logic [9:0]          slew_cnt;

   logic [7:0]          taps;
   logic                args_ok;
   logic [NCO_BITS:0]   nco_sum;
   logic                carry;
   logic                wrap;
   logic                load;
   logic                hold_off;
   logic                lfsr_adv;
   logic                lfsr_reseed;

   // Start validation, NCO carry and LFSR control decode
   always_comb begin
      taps        = prn_taps(prn);
      args_ok     = (prn != 6'd0) && (32'(prn) <= PRN_MAX) && (32'(init_phase) < CA_LEN);
      nco_sum     = {1'b0, nco} + {1'b0, code_freq};
      carry       = (state == RUN) && sample_en && nco_sum[NCO_BITS];
      wrap        = carry && (chip_idx == 10'(CA_LEN - 1));
      load        = !stop && start && args_ok;
      hold_off    = stop || load;
      lfsr_adv    = !hold_off && ((state == SLEW) || (carry && !wrap));
      lfsr_reseed = !hold_off && wrap;
   end

   // Controller: stop > valid start > state activity
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         nco      <= '0;
         slew_cnt <= 10'd0;
         chip_idx <= 10'd0;
         chip_adv <= 1'b0;
         epoch    <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
      end else begin
         chip_adv <= 1'b0;
         epoch    <= 1'b0;
         err      <= 1'b0;
         if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else if (load) begin
            state    <= (init_phase == 10'd0) ? RUN : SLEW;
            busy     <= 1'b1;
            nco      <= '0;
            chip_idx <= 10'd0;
            slew_cnt <= init_phase;
         end else begin
            if (start) err <= 1'b1;
            case (state)
               SLEW: begin
                  slew_cnt <= slew_cnt - 10'd1;
                  chip_idx <= chip_idx + 10'd1;
                  if (slew_cnt == 10'd1) state <= RUN;
               end
               RUN: begin
                  if (sample_en) begin
                     nco <= nco_sum[NCO_BITS-1:0];
                     if (carry) begin
                        chip_adv <= 1'b1;
                        if (wrap) begin
                           chip_idx <= 10'd0;
                           epoch    <= 1'b1;
                        end else begin
                           chip_idx <= chip_idx + 10'd1;
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   gps_ca_lfsr u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .reseed (lfsr_reseed),
      .adv    (lfsr_adv),
      .en     (busy),
      .tap1   (taps[7:4]),
      .tap2   (taps[3:0]),
      .chip   (chip)
   );

endmodule

// File: tb/tb_gps_ca_code_gen.sv
// Self-checking bench for gps_ca_code_gen: constant vector table, directed
// corner sequences and randomized traffic against a behavioural model that
// builds the Gold codes from G1/G2 recurrences and per-PRN G2 chip delays.
module tb_gps_ca_code_gen;

   logic        clk;
   logic        rst;
   logic        start;
   logic        stop;
   logic [5:0]  prn;
   logic [9:0]  init_phase;
   logic [31:0] code_freq;
   logic        sample_en;
   logic        chip;
   logic [9:0]  chip_idx;
   logic        chip_adv;
   logic        epoch;
   logic        busy;
   logic        err;

   gps_ca_code_gen #(.NCO_BITS(32), .CA_LEN(1023)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .prn        (prn),
      .init_phase (init_phase),
      .code_freq  (code_freq),
      .sample_en  (sample_en),
      .chip       (chip),
      .chip_idx   (chip_idx),
      .chip_adv   (chip_adv),
      .epoch      (epoch),
      .busy       (busy),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Reference sequences: G1/G2 stage-10 output streams, and G2 delay per PRN
   int g1s [0:1022];
   int g2s [0:1022];
   int dly [0:32] = '{0, 5, 6, 7, 8, 17, 18, 139, 140, 141, 251, 252, 254, 255,
                      256, 257, 258, 469, 470, 471, 472, 473, 474, 509, 512, 513,
                      514, 515, 516, 859, 860, 861, 862};

   // Model state: mode 0 idle, 1 slewing, 2 running
   int              m_mode;
   int              m_idx;
   int              m_left;
   int              m_delay;
   longint unsigned m_nco;
   int              m_adv;
   int              m_epoch;
   int              m_err;

   function automatic int ca_chip(int d, int k);
      return g1s[k] ^ g2s[(k + 1023 - d) % 1023];
   endfunction

   task automatic check(string name, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_step();
      bit valid;
      longint unsigned s;
      valid   = (prn >= 1) && (prn <= 32) && (init_phase <= 1022);
      m_adv   = 0;
      m_epoch = 0;
      m_err   = 0;
      if (rst) begin
         m_mode = 0; m_idx = 0; m_left = 0; m_nco = 0;
      end else if (stop) begin
         m_mode = 0;
      end else if (start && valid) begin
         m_mode  = (init_phase == 0) ? 2 : 1;
         m_idx   = 0;
         m_nco   = 0;
         m_left  = int'(init_phase);
         m_delay = dly[prn];
      end else begin
         if (start) m_err = 1;
         if (m_mode == 1) begin
            m_idx++;
            m_left--;
            if (m_left == 0) m_mode = 2;
         end else if (m_mode == 2 && sample_en) begin
            s = m_nco + longint'(code_freq);
            if (s >= 64'h1_0000_0000) begin
               m_adv   = 1;
               m_idx   = (m_idx + 1) % 1023;
               m_epoch = (m_idx == 0);
            end
            m_nco = s & 64'hFFFF_FFFF;
         end
      end
   endtask

   // One clock: update model, clock DUT, compare all outputs on the falling edge
   task automatic step();
      int exp_chip;
      model_step();
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      exp_chip = (m_mode != 0) ? ca_chip(m_delay, m_idx) : 0;
      check("busy",     int'(busy),     int'(m_mode != 0));
      check("chip_idx", int'(chip_idx), m_idx);
      check("chip",     int'(chip),     exp_chip);
      check("chip_adv", int'(chip_adv), m_adv);
      check("epoch",    int'(epoch),    m_epoch);
      check("err",      int'(err),      m_err);
   endtask

   task automatic do_start(int p, int ph, logic [31:0] f);
      prn        = 6'(p);
      init_phase = 10'(ph);
      code_freq  = f;
      start      = 1'b1;
      step();
   endtask

   typedef struct {
      int p;
      int phase;
      int exp_err;
      int nchk;
      int bits;
   } vec_t;

   vec_t tbl [0:6];

   initial begin
      int got, n, steps, cnt;

      for (int k = 0; k < 1023; k++) begin
         if (k < 10) begin
            g1s[k] = 1;
            g2s[k] = 1;
         end else begin
            g1s[k] = g1s[k-3] ^ g1s[k-10];
            g2s[k] = g2s[k-2] ^ g2s[k-3] ^ g2s[k-6] ^ g2s[k-8] ^ g2s[k-9] ^ g2s[k-10];
         end
      end
      m_mode = 0; m_idx = 0; m_left = 0; m_delay = 0; m_nco = 0;

      tbl[0] = '{0,  0,    1, 0,  0};
      tbl[1] = '{33, 0,    1, 0,  0};
      tbl[2] = '{1,  1023, 1, 0,  0};
      tbl[3] = '{1,  0,    0, 10, 10'o1440};
      tbl[4] = '{2,  0,    0, 10, 10'o1620};
      tbl[5] = '{3,  0,    0, 10, 10'o1710};
      tbl[6] = '{1,  5,    0, 5,  0};

      rst = 1'b1; start = 1'b0; stop = 1'b0; prn = 6'd0;
      init_phase = 10'd0; code_freq = 32'd0; sample_en = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();

      // Table: invalid starts from idle, then first chips (restarts mid-stream)
      sample_en = 1'b1;
      for (int i = 0; i <= 6; i++) begin
         do_start(tbl[i].p, tbl[i].phase, 32'h8000_0000);
         if (tbl[i].exp_err != 0) begin
            check("tbl_err",  int'(err),  1);
            check("tbl_idle", int'(busy), 0);
         end else begin
            for (int j = 0; j < tbl[i].phase; j++) step();
            check("tbl_phase", int'(chip_idx), tbl[i].phase);
            got = int'(chip);
            n = 1;
            steps = 0;
            while (n < tbl[i].nchk && steps < 4 * tbl[i].nchk) begin
               step();
               steps++;
               if (chip_adv) begin
                  got = (got << 1) | int'(chip);
                  n++;
               end
            end
            check("tbl_chips", got, tbl[i].bits);
            check("tbl_adv_spacing", steps, 2 * (tbl[i].nchk - 1));
         end
      end

      // Full period: exactly one epoch, index back at 0
      do_start(2, 0, 32'h8000_0000);
      cnt = 0;
      for (int j = 0; j < 2046; j++) begin
         step();
         cnt += int'(epoch);
      end
      check("epoch_count", cnt, 1);
      check("wrap_idx", int'(chip_idx), 0);
      for (int j = 0; j < 24; j++) step();

      // start and stop together -> idle
      prn = 6'd4; init_phase = 10'd0; start = 1'b1; stop = 1'b1;
      step();
      check("stop_wins_busy", int'(busy), 0);
      check("stop_wins_chip", int'(chip), 0);

      // Reset during SLEW
      do_start(7, 100, 32'h4000_0000);
      for (int j = 0; j < 10; j++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_slew_idx",  int'(chip_idx), 0);
      check("rst_slew_busy", int'(busy), 0);

      // Reset during RUN
      do_start(9, 0, 32'h9000_0000);
      for (int j = 0; j < 20; j++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_run_idx", int'(chip_idx), 0);
      check("rst_run_adv", int'(chip_adv), 0);

      // Zero code frequency freezes the code
      do_start(5, 0, 32'd0);
      cnt = 0;
      for (int j = 0; j < 100; j++) begin
         step();
         cnt += int'(chip_adv);
      end
      check("freeze_adv", cnt, 0);

      // Randomized traffic against the model
      for (int r = 0; r < 8; r++) begin
         do_start(int'($urandom_range(1, 32)),
                  (r % 3 == 0) ? int'($urandom_range(900, 1022)) : int'($urandom_range(0, 60)),
                  $urandom);
         for (int j = 0; j < 400; j++) begin
            sample_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) begin
               prn        = 6'($urandom_range(0, 34));
               init_phase = 10'($urandom_range(0, 1023));
               code_freq  = $urandom;
               start      = 1'b1;
            end
            if ($urandom_range(0, 199) == 0) stop = 1'b1;
            step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
